// File: rtl/axilite_reg_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to register-request bridge.
package axilite_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_REQ,
    R_WAIT,
    R_RESP
  } rd_state_t;

endpackage

// File: rtl/axilite_reg_bridge_if.sv
// AXI4-Lite bus bundle. The bridge is the slave; the interconnect is the master.
interface axilite_reg_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  localparam int STRB_W = DATA_W / 8;

  logic              AXI_AWVALID;
  logic              AXI_AWREADY;
  logic [ADDR_W-1:0] AXI_AWADDR;
  logic              AXI_WVALID;
  logic              AXI_WREADY;
  logic [DATA_W-1:0] AXI_WDATA;
  logic [STRB_W-1:0] AXI_WSTRB;
  logic              AXI_BVALID;
  logic              AXI_BREADY;
  logic [1:0]        AXI_BRESP;
  logic              AXI_ARVALID;
  logic              AXI_ARREADY;
  logic [ADDR_W-1:0] AXI_ARADDR;
  logic              AXI_RVALID;
  logic              AXI_RREADY;
  logic [DATA_W-1:0] AXI_RDATA;
  logic [1:0]        AXI_RRESP;

  modport slave (
    input  AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA, AXI_WSTRB, AXI_BREADY,
           AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
    output AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
           AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
  );

  modport master (
    output AXI_AWVALID, AXI_AWADDR, AXI_WVALID, AXI_WDATA, AXI_WSTRB, AXI_BREADY,
           AXI_ARVALID, AXI_ARADDR, AXI_RREADY,
    input  AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP,
           AXI_ARREADY, AXI_RVALID, AXI_RDATA, AXI_RRESP
  );

endinterface

// File: rtl/axilite_req_timer.sv
// Ack-wait timer: counts cycles while enabled, holds at all-ones, and flags
// expiry on the cycle the count reaches limit-1 so the response lands exactly
// limit cycles after the request strobe.
module axilite_req_timer
  import axilite_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] count;

  // Saturating cycle counter, zeroed while the owning FSM is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign expired = enable && (count == (limit - TIMER_W'(1)));

endmodule

// File: rtl/axilite_reg_bridge.sv
// AXI4-Lite slave to single-cycle register request bridge. Independent read
// and write FSMs, one outstanding transaction per direction, DECERR for
// addresses above ADDR_LIMIT and SLVERR on user error or ack timeout.
module axilite_reg_bridge
  import axilite_pkg::*;
#(
  parameter int              ADDR_W     = 16,
  parameter int              DATA_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h00FF,
  parameter int              TIMEOUT    = 32,
  parameter int              STRB_W     = DATA_W / 8,
  parameter int              WA_W       = ADDR_W - $clog2(STRB_W)
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_RESETN,
  axilite_reg_bridge_if.slave axi,
  output logic                usr_wreq,
  output logic [WA_W-1:0]     usr_waddr,
  output logic [DATA_W-1:0]   usr_wdata,
  output logic [STRB_W-1:0]   usr_wstrb,
  input  logic                usr_wack,
  input  logic                usr_werr,
  output logic                usr_rreq,
  output logic [WA_W-1:0]     usr_raddr,
  input  logic [DATA_W-1:0]   usr_rdata,
  input  logic                usr_rack,
  input  logic                usr_rerr
);

  localparam int LSB = $clog2(STRB_W);

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("axilite_reg_bridge: DATA_W must be 32 or 64");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axilite_reg_bridge: TIMEOUT must be in 2..65535");
  end

  // ---------------- write path ----------------
  wr_state_t         wr_state, wr_next;
  axi_resp_t         bresp_q, bresp_nxt;
  logic              awready_q, wready_q, aw_got, w_got;
  logic              aw_hs, w_hs, aw_have, w_have, wr_expired;
  logic [ADDR_W-1:0] awaddr_q, awaddr_eff;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  assign aw_hs      = axi.AXI_AWVALID && awready_q;
  assign w_hs       = axi.AXI_WVALID && wready_q;
  assign aw_have    = aw_got || aw_hs;
  assign w_have     = w_got || w_hs;
  assign awaddr_eff = aw_hs ? axi.AXI_AWADDR : awaddr_q;

  // Write next-state and response selection; the last of AW/W completing
  // decides between issuing a request and answering DECERR directly.
  always_comb begin
    wr_next   = wr_state;
    bresp_nxt = bresp_q;
    case (wr_state)
      W_IDLE: begin
        if (aw_have && w_have) begin
          if (awaddr_eff <= ADDR_LIMIT) begin
            wr_next = W_REQ;
          end else begin
            wr_next   = W_RESP;
            bresp_nxt = DECERR;
          end
        end
      end
      W_REQ, W_WAIT: begin
        if (usr_wack) begin
          wr_next   = W_RESP;
          bresp_nxt = usr_werr ? SLVERR : OKAY;
        end else if (wr_expired) begin
          wr_next   = W_RESP;
          bresp_nxt = SLVERR;
        end else begin
          wr_next = W_WAIT;
        end
      end
      W_RESP: begin
        if (axi.AXI_BREADY) begin
          wr_next   = W_IDLE;
          bresp_nxt = OKAY;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Write state register.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) wr_state <= W_IDLE;
    else             wr_state <= wr_next;
  end

  // AW/W capture, per-channel ready tracking and the held write response.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
    end else begin
      aw_got    <= (wr_state == W_IDLE) && (wr_next == W_IDLE) && aw_have;
      w_got     <= (wr_state == W_IDLE) && (wr_next == W_IDLE) && w_have;
      awready_q <= (wr_next == W_IDLE) && !((wr_state == W_IDLE) && aw_have);
      wready_q  <= (wr_next == W_IDLE) && !((wr_state == W_IDLE) && w_have);
      bresp_q   <= bresp_nxt;
      if (aw_hs) awaddr_q <= axi.AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= axi.AXI_WDATA;
        wstrb_q <= axi.AXI_WSTRB;
      end
    end
  end

  axilite_req_timer u_wr_timer (
    .clk     (AXI_ACLK),
    .rst_n   (AXI_RESETN),
    .clear   (wr_state == W_IDLE),
    .enable  ((wr_state == W_REQ) || (wr_state == W_WAIT)),
    .limit   (TIMER_W'(TIMEOUT)),
    .expired (wr_expired)
  );

  assign usr_wreq        = (wr_state == W_REQ);
  assign usr_waddr       = awaddr_q[ADDR_W-1:LSB];
  assign usr_wdata       = wdata_q;
  assign usr_wstrb       = wstrb_q;
  assign axi.AXI_AWREADY = awready_q;
  assign axi.AXI_WREADY  = wready_q;
  assign axi.AXI_BVALID  = (wr_state == W_RESP);
  assign axi.AXI_BRESP   = bresp_q;

  // ---------------- read path ----------------
  rd_state_t         rd_state, rd_next;
  axi_resp_t         rresp_q, rresp_nxt;
  logic              arready_q, ar_hs, rd_expired;
  logic [WA_W-1:0]   araddr_q;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  assign ar_hs = axi.AXI_ARVALID && arready_q;

  // Read next-state, response and captured data; RDATA is zero unless a
  // real ack supplied it.
  always_comb begin
    rd_next   = rd_state;
    rresp_nxt = rresp_q;
    rdata_nxt = rdata_q;
    case (rd_state)
      R_IDLE: begin
        if (ar_hs) begin
          if (axi.AXI_ARADDR <= ADDR_LIMIT) begin
            rd_next = R_REQ;
          end else begin
            rd_next   = R_RESP;
            rresp_nxt = DECERR;
            rdata_nxt = '0;
          end
        end
      end
      R_REQ, R_WAIT: begin
        if (usr_rack) begin
          rd_next   = R_RESP;
          rresp_nxt = usr_rerr ? SLVERR : OKAY;
          rdata_nxt = usr_rdata;
        end else if (rd_expired) begin
          rd_next   = R_RESP;
          rresp_nxt = SLVERR;
          rdata_nxt = '0;
        end else begin
          rd_next = R_WAIT;
        end
      end
      R_RESP: begin
        if (axi.AXI_RREADY) begin
          rd_next   = R_IDLE;
          rresp_nxt = OKAY;
          rdata_nxt = '0;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // Read state register.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) rd_state <= R_IDLE;
    else             rd_state <= rd_next;
  end

  // AR capture, ready tracking and the held read response.
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      arready_q <= 1'b0;
      araddr_q  <= '0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= (rd_next == R_IDLE);
      rresp_q   <= rresp_nxt;
      rdata_q   <= rdata_nxt;
      if (ar_hs) araddr_q <= axi.AXI_ARADDR[ADDR_W-1:LSB];
    end
  end

  axilite_req_timer u_rd_timer (
    .clk     (AXI_ACLK),
    .rst_n   (AXI_RESETN),
    .clear   (rd_state == R_IDLE),
    .enable  ((rd_state == R_REQ) || (rd_state == R_WAIT)),
    .limit   (TIMER_W'(TIMEOUT)),
    .expired (rd_expired)
  );

  assign usr_rreq        = (rd_state == R_REQ);
  assign usr_raddr       = araddr_q;
  assign axi.AXI_ARREADY = arready_q;
  assign axi.AXI_RVALID  = (rd_state == R_RESP);
  assign axi.AXI_RDATA   = rdata_q;
  assign axi.AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axilite_reg_bridge.sv
// Directed bench for axilite_reg_bridge: a 32-bit instance (TIMEOUT=8) covers
// ordering, DECERR, user error, timeout and reset abort; a 64-bit instance
// repeats the concurrent read/write case.
module tb_axilite_reg_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axilite_reg_bridge_if #(.ADDR_W(16), .DATA_W(32)) bus32 ();
  axilite_reg_bridge_if #(.ADDR_W(16), .DATA_W(64)) bus64 ();

  logic        a_wreq, a_wack, a_werr, a_rreq, a_rack, a_rerr;
  logic [13:0] a_waddr, a_raddr;
  logic [31:0] a_wdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic        b_wreq, b_wack, b_werr, b_rreq, b_rack, b_rerr;
  logic [12:0] b_waddr, b_raddr;
  logic [63:0] b_wdata, b_rdata;
  logic [7:0]  b_wstrb;

  axilite_reg_bridge #(.ADDR_W(16), .DATA_W(32), .ADDR_LIMIT(16'h00FF), .TIMEOUT(8)) dut32 (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n), .axi(bus32.slave),
    .usr_wreq(a_wreq), .usr_waddr(a_waddr), .usr_wdata(a_wdata), .usr_wstrb(a_wstrb),
    .usr_wack(a_wack), .usr_werr(a_werr), .usr_rreq(a_rreq), .usr_raddr(a_raddr),
    .usr_rdata(a_rdata), .usr_rack(a_rack), .usr_rerr(a_rerr));

  axilite_reg_bridge #(.ADDR_W(16), .DATA_W(64), .ADDR_LIMIT(16'h00FF), .TIMEOUT(8)) dut64 (
    .AXI_ACLK(clk), .AXI_RESETN(rst_n), .axi(bus64.slave),
    .usr_wreq(b_wreq), .usr_waddr(b_waddr), .usr_wdata(b_wdata), .usr_wstrb(b_wstrb),
    .usr_wack(b_wack), .usr_werr(b_werr), .usr_rreq(b_rreq), .usr_raddr(b_raddr),
    .usr_rdata(b_rdata), .usr_rack(b_rack), .usr_rerr(b_rerr));

  int n_chk = 0;
  int n_fail = 0;
  int a_wreq_cnt = 0;

  always @(posedge clk) if (a_wreq) a_wreq_cnt <= a_wreq_cnt + 1;

  typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wreq_t;
  typedef struct { logic [63:0] data; logic [1:0] resp; } rrsp_t;
  wreq_t       q_wreq[$];
  logic [63:0] q_rreq[$];
  logic [1:0]  q_b[$];
  rrsp_t       q_r[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic empty_q(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: DUT produced output with nothing expected", tag);
  endtask

  task automatic pop_wreq(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s);
    wreq_t e;
    if (q_wreq.size() == 0) empty_q(tag);
    else begin
      e = q_wreq.pop_front();
      chk({tag, "_waddr"}, a, e.addr);
      chk({tag, "_wdata"}, d, e.data);
      chk({tag, "_wstrb"}, 64'(s), 64'(e.strb));
    end
  endtask

  task automatic pop_rreq(input string tag, input logic [63:0] a);
    logic [63:0] e;
    if (q_rreq.size() == 0) empty_q(tag);
    else begin
      e = q_rreq.pop_front();
      chk({tag, "_raddr"}, a, e);
    end
  endtask

  task automatic pop_b(input string tag, input logic [1:0] r);
    logic [1:0] e;
    if (q_b.size() == 0) empty_q(tag);
    else begin
      e = q_b.pop_front();
      chk({tag, "_bresp"}, 64'(r), 64'(e));
    end
  endtask

  task automatic pop_r(input string tag, input logic [63:0] d, input logic [1:0] r);
    rrsp_t e;
    if (q_r.size() == 0) empty_q(tag);
    else begin
      e = q_r.pop_front();
      chk({tag, "_rdata"}, d, e.data);
      chk({tag, "_rresp"}, 64'(r), 64'(e.resp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    bus32.AXI_AWVALID = 0; bus32.AXI_AWADDR = '0; bus32.AXI_WVALID = 0; bus32.AXI_WDATA = '0;
    bus32.AXI_WSTRB = '0; bus32.AXI_BREADY = 0; bus32.AXI_ARVALID = 0; bus32.AXI_ARADDR = '0;
    bus32.AXI_RREADY = 0;
    bus64.AXI_AWVALID = 0; bus64.AXI_AWADDR = '0; bus64.AXI_WVALID = 0; bus64.AXI_WDATA = '0;
    bus64.AXI_WSTRB = '0; bus64.AXI_BREADY = 0; bus64.AXI_ARVALID = 0; bus64.AXI_ARADDR = '0;
    bus64.AXI_RREADY = 0;
    a_wack = 0; a_werr = 0; a_rack = 0; a_rerr = 0; a_rdata = '0;
    b_wack = 0; b_werr = 0; b_rack = 0; b_rerr = 0; b_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_awready", 64'(bus32.AXI_AWREADY), 64'd0);
    chk("rst_wready", 64'(bus32.AXI_WREADY), 64'd0);
    chk("rst_arready", 64'(bus32.AXI_ARREADY), 64'd0);
    chk("rst_bvalid", 64'(bus32.AXI_BVALID), 64'd0);
    chk("rst_rvalid", 64'(bus32.AXI_RVALID), 64'd0);
    chk("rst_wreq", 64'(a_wreq), 64'd0);
    rst_n = 1;
    tick();
    chk("post_rst_awready", 64'(bus32.AXI_AWREADY), 64'd1);
    chk("post_rst_wready", 64'(bus32.AXI_WREADY), 64'd1);
    chk("post_rst_arready", 64'(bus32.AXI_ARREADY), 64'd1);

    // W before AW, two cycles apart
    bus32.AXI_WVALID = 1; bus32.AXI_WDATA = 32'hDEADBEEF; bus32.AXI_WSTRB = 4'b0011;
    tick();
    bus32.AXI_WVALID = 0;
    chk("t1_wready_drop", 64'(bus32.AXI_WREADY), 64'd0);
    chk("t1_awready_hold", 64'(bus32.AXI_AWREADY), 64'd1);
    chk("t1_no_early_wreq", 64'(a_wreq), 64'd0);
    tick(); tick();
    bus32.AXI_AWVALID = 1; bus32.AXI_AWADDR = 16'h0004;
    q_wreq.push_back('{addr: 64'd1, data: 64'hDEADBEEF, strb: 8'h03});
    q_b.push_back(2'b00);
    tick();
    bus32.AXI_AWVALID = 0;
    chk("t1_wreq", 64'(a_wreq), 64'd1);
    pop_wreq("t1", 64'(a_waddr), 64'(a_wdata), 8'(a_wstrb));
    cnt0 = a_wreq_cnt;
    tick();
    chk("t1_wreq_one_cycle", 64'(a_wreq), 64'd0);
    chk("t1_awready_busy", 64'(bus32.AXI_AWREADY), 64'd0);
    tick(); tick();
    chk("t1_bvalid_wait", 64'(bus32.AXI_BVALID), 64'd0);
    a_wack = 1;
    tick();
    a_wack = 0;
    chk("t1_bvalid", 64'(bus32.AXI_BVALID), 64'd1);
    pop_b("t1", bus32.AXI_BRESP);
    chk("t1_wreq_count", 64'(a_wreq_cnt - cnt0), 64'd1);
    bus32.AXI_BREADY = 1;
    tick();
    bus32.AXI_BREADY = 0;
    chk("t1_bvalid_clear", 64'(bus32.AXI_BVALID), 64'd0);
    chk("t1_awready_back", 64'(bus32.AXI_AWREADY), 64'd1);
    chk("t1_wready_back", 64'(bus32.AXI_WREADY), 64'd1);

    // Write above ADDR_LIMIT: DECERR, no user request, response held
    cnt0 = a_wreq_cnt;
    bus32.AXI_AWVALID = 1; bus32.AXI_AWADDR = 16'h0100;
    bus32.AXI_WVALID = 1; bus32.AXI_WDATA = 32'h11111111; bus32.AXI_WSTRB = 4'hF;
    q_b.push_back(2'b11);
    tick();
    bus32.AXI_AWVALID = 0; bus32.AXI_WVALID = 0;
    chk("t2_bvalid", 64'(bus32.AXI_BVALID), 64'd1);
    pop_b("t2", bus32.AXI_BRESP);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_bvalid_hold", 64'(bus32.AXI_BVALID), 64'd1);
      chk("t2_bresp_hold", 64'(bus32.AXI_BRESP), 64'd3);
    end
    chk("t2_no_wreq", 64'(a_wreq_cnt - cnt0), 64'd0);
    bus32.AXI_BREADY = 1;
    tick();
    bus32.AXI_BREADY = 0;
    chk("t2_bvalid_clear", 64'(bus32.AXI_BVALID), 64'd0);

    // Read with user error after 4 cycles
    bus32.AXI_ARVALID = 1; bus32.AXI_ARADDR = 16'h0008;
    q_rreq.push_back(64'd2);
    q_r.push_back('{data: 64'h12345678, resp: 2'b10});
    tick();
    bus32.AXI_ARVALID = 0;
    chk("t3_rreq", 64'(a_rreq), 64'd1);
    pop_rreq("t3", 64'(a_raddr));
    chk("t3_arready_drop", 64'(bus32.AXI_ARREADY), 64'd0);
    tick(); tick(); tick();
    chk("t3_rvalid_wait", 64'(bus32.AXI_RVALID), 64'd0);
    tick();
    a_rack = 1; a_rerr = 1; a_rdata = 32'h12345678;
    tick();
    a_rack = 0; a_rerr = 0; a_rdata = 32'hFFFFFFFF;
    chk("t3_rvalid", 64'(bus32.AXI_RVALID), 64'd1);
    pop_r("t3", 64'(bus32.AXI_RDATA), bus32.AXI_RRESP);
    tick();
    chk("t3_rdata_hold", 64'(bus32.AXI_RDATA), 64'h12345678);
    bus32.AXI_RREADY = 1;
    tick();
    bus32.AXI_RREADY = 0;
    chk("t3_rvalid_clear", 64'(bus32.AXI_RVALID), 64'd0);
    chk("t3_arready_back", 64'(bus32.AXI_ARREADY), 64'd1);

    // Read timeout (TIMEOUT=8), late ack ignored
    bus32.AXI_ARVALID = 1; bus32.AXI_ARADDR = 16'h0010;
    q_rreq.push_back(64'd4);
    q_r.push_back('{data: 64'd0, resp: 2'b10});
    tick();
    bus32.AXI_ARVALID = 0;
    chk("t4_rreq", 64'(a_rreq), 64'd1);
    pop_rreq("t4", 64'(a_raddr));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t4_rvalid_early", 64'(bus32.AXI_RVALID), 64'd0);
    end
    tick();
    chk("t4_rvalid", 64'(bus32.AXI_RVALID), 64'd1);
    pop_r("t4", 64'(bus32.AXI_RDATA), bus32.AXI_RRESP);
    a_rack = 1; a_rdata = 32'hAAAA5555;
    tick();
    a_rack = 0;
    chk("t4_late_rdata", 64'(bus32.AXI_RDATA), 64'd0);
    chk("t4_late_rresp", 64'(bus32.AXI_RRESP), 64'd2);
    bus32.AXI_RREADY = 1;
    tick();
    bus32.AXI_RREADY = 0;

    // Concurrent write and read, 32-bit
    bus32.AXI_AWVALID = 1; bus32.AXI_AWADDR = 16'h0020;
    bus32.AXI_WVALID = 1; bus32.AXI_WDATA = 32'hCAFEF00D; bus32.AXI_WSTRB = 4'hF;
    bus32.AXI_ARVALID = 1; bus32.AXI_ARADDR = 16'h0030;
    q_wreq.push_back('{addr: 64'd8, data: 64'hCAFEF00D, strb: 8'h0F});
    q_rreq.push_back(64'd12);
    q_b.push_back(2'b00);
    q_r.push_back('{data: 64'h5A5A5A5A, resp: 2'b00});
    tick();
    bus32.AXI_AWVALID = 0; bus32.AXI_WVALID = 0; bus32.AXI_ARVALID = 0;
    chk("t5_wreq", 64'(a_wreq), 64'd1);
    chk("t5_rreq", 64'(a_rreq), 64'd1);
    pop_wreq("t5", 64'(a_waddr), 64'(a_wdata), 8'(a_wstrb));
    pop_rreq("t5", 64'(a_raddr));
    a_wack = 1; a_rack = 1; a_rdata = 32'h5A5A5A5A;
    tick();
    a_wack = 0; a_rack = 0;
    chk("t5_bvalid", 64'(bus32.AXI_BVALID), 64'd1);
    chk("t5_rvalid", 64'(bus32.AXI_RVALID), 64'd1);
    pop_b("t5", bus32.AXI_BRESP);
    pop_r("t5", 64'(bus32.AXI_RDATA), bus32.AXI_RRESP);
    bus32.AXI_BREADY = 1; bus32.AXI_RREADY = 1;
    tick();
    bus32.AXI_BREADY = 0; bus32.AXI_RREADY = 0;
    chk("t5_bvalid_clear", 64'(bus32.AXI_BVALID), 64'd0);
    chk("t5_rvalid_clear", 64'(bus32.AXI_RVALID), 64'd0);

    // Concurrent write and read, 64-bit
    bus64.AXI_AWVALID = 1; bus64.AXI_AWADDR = 16'h0018;
    bus64.AXI_WVALID = 1; bus64.AXI_WDATA = 64'h0123456789ABCDEF; bus64.AXI_WSTRB = 8'hF0;
    bus64.AXI_ARVALID = 1; bus64.AXI_ARADDR = 16'h0028;
    q_wreq.push_back('{addr: 64'd3, data: 64'h0123456789ABCDEF, strb: 8'hF0});
    q_rreq.push_back(64'd5);
    q_b.push_back(2'b10);
    q_r.push_back('{data: 64'hFEDCBA9876543210, resp: 2'b00});
    tick();
    bus64.AXI_AWVALID = 0; bus64.AXI_WVALID = 0; bus64.AXI_ARVALID = 0;
    chk("t6_wreq", 64'(b_wreq), 64'd1);
    chk("t6_rreq", 64'(b_rreq), 64'd1);
    pop_wreq("t6", 64'(b_waddr), b_wdata, b_wstrb);
    pop_rreq("t6", 64'(b_raddr));
    b_wack = 1; b_werr = 1; b_rack = 1; b_rdata = 64'hFEDCBA9876543210;
    tick();
    b_wack = 0; b_werr = 0; b_rack = 0;
    for (int i = 0; i < 16 && !(bus64.AXI_BVALID && bus64.AXI_RVALID); i++) tick();
    chk("t6_bvalid", 64'(bus64.AXI_BVALID), 64'd1);
    chk("t6_rvalid", 64'(bus64.AXI_RVALID), 64'd1);
    pop_b("t6", bus64.AXI_BRESP);
    pop_r("t6", bus64.AXI_RDATA, bus64.AXI_RRESP);
    bus64.AXI_BREADY = 1; bus64.AXI_RREADY = 1;
    tick();
    bus64.AXI_BREADY = 0; bus64.AXI_RREADY = 0;
    chk("t6_bvalid_clear", 64'(bus64.AXI_BVALID), 64'd0);

    // Reset asserted while the write waits for its ack
    bus32.AXI_AWVALID = 1; bus32.AXI_AWADDR = 16'h000C;
    bus32.AXI_WVALID = 1; bus32.AXI_WDATA = 32'h77777777; bus32.AXI_WSTRB = 4'hF;
    tick();
    bus32.AXI_AWVALID = 0; bus32.AXI_WVALID = 0;
    chk("t7_wreq", 64'(a_wreq), 64'd1);
    tick();
    #2 rst_n = 0;
    #1;
    chk("t7_awready", 64'(bus32.AXI_AWREADY), 64'd0);
    chk("t7_wready", 64'(bus32.AXI_WREADY), 64'd0);
    chk("t7_bvalid", 64'(bus32.AXI_BVALID), 64'd0);
    chk("t7_bresp", 64'(bus32.AXI_BRESP), 64'd0);
    chk("t7_arready", 64'(bus32.AXI_ARREADY), 64'd0);
    chk("t7_rvalid", 64'(bus32.AXI_RVALID), 64'd0);
    chk("t7_rdata", 64'(bus32.AXI_RDATA), 64'd0);
    chk("t7_wreq_rst", 64'(a_wreq), 64'd0);
    chk("t7_waddr", 64'(a_waddr), 64'd0);
    chk("t7_wdata", 64'(a_wdata), 64'd0);
    chk("t7_wstrb", 64'(a_wstrb), 64'd0);
    chk("t7_rreq", 64'(a_rreq), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("t7_awready_after", 64'(bus32.AXI_AWREADY), 64'd1);
    chk("t7_wready_after", 64'(bus32.AXI_WREADY), 64'd1);
    chk("t7_no_stale_b", 64'(bus32.AXI_BVALID), 64'd0);
    a_wack = 1;
    tick();
    a_wack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_stale_ack_ignored", 64'(bus32.AXI_BVALID), 64'd0);
    end
    chk("sb_wreq_drained", 64'(q_wreq.size()), 64'd0);
    chk("sb_b_drained", 64'(q_b.size()), 64'd0);
    chk("sb_r_drained", 64'(q_r.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
